// File: rtl/action_mod_sequencer.sv
// action_mod_sequencer: steps one looked-up action through a rule-table read, an optional modifier pass and an output handshake
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   act_vld/act_in/rule_hit/rule_idx, act_rdy    upstream action and its rule index
//   mod_enable/mod_action/mod_param/mod_flag     request to the action modifier
//   mod_result/mod_done        modified action returned by the modifier
//   out_vld/out_action/out_rdy downstream result handshake
//   tbl_wr_*                   software write port of the rule table
//   cnt_modified/cnt_bypass    wrapping counts of modified and bypassed actions
`ifndef OPENFLOW_ACTION_WIDTH
`define OPENFLOW_ACTION_WIDTH 64
`endif
module action_mod_sequencer #(
    parameter int ACTION_WIDTH   = `OPENFLOW_ACTION_WIDTH,
    parameter int FLAG_WIDTH     = 16,
    parameter int RULE_IDX_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      act_vld,
    input  logic [ACTION_WIDTH-1:0]   act_in,
    input  logic                      rule_hit,
    input  logic [RULE_IDX_WIDTH-1:0] rule_idx,
    output logic                      act_rdy,
    output logic                      mod_enable,
    output logic [ACTION_WIDTH-1:0]   mod_action,
    output logic [ACTION_WIDTH-1:0]   mod_param,
    output logic [FLAG_WIDTH-1:0]     mod_flag,
    input  logic [ACTION_WIDTH-1:0]   mod_result,
    input  logic                      mod_done,
    output logic                      out_vld,
    output logic [ACTION_WIDTH-1:0]   out_action,
    input  logic                      out_rdy,
    input  logic                      tbl_wr_en,
    input  logic [RULE_IDX_WIDTH-1:0] tbl_wr_addr,
    input  logic [ACTION_WIDTH-1:0]   tbl_wr_param,
    input  logic [FLAG_WIDTH-1:0]     tbl_wr_flag,
    output logic [31:0]               cnt_modified,
    output logic [31:0]               cnt_bypass
);
    typedef enum logic [2:0] {IDLE, READ, MOD, WAIT, OUT} state_t;
    state_t state_q, state_d;
    logic [ACTION_WIDTH-1:0] tbl_param_q [2**RULE_IDX_WIDTH];
    logic [FLAG_WIDTH-1:0]   tbl_flag_q  [2**RULE_IDX_WIDTH];
    logic [ACTION_WIDTH-1:0] rd_param_q, act_q, out_action_q, mod_action_q, mod_param_q;
    logic [FLAG_WIDTH-1:0]   rd_flag_q, mod_flag_q;
    logic                    hit_q;
    logic [31:0]             cnt_mod_q, cnt_byp_q;
    logic                    accept, do_mod;
    assign accept = (state_q == IDLE) && act_vld;
    assign do_mod = hit_q && (rd_flag_q != '0);
    // Read and write share one process, so a same-address write in the accept
    // cycle is seen only by the next action.
    always_ff @(posedge clk) begin
        if (tbl_wr_en) begin
            tbl_param_q[tbl_wr_addr] <= tbl_wr_param;
            tbl_flag_q[tbl_wr_addr]  <= tbl_wr_flag;
        end
        if (accept) begin
            rd_param_q <= tbl_param_q[rule_idx];
            rd_flag_q  <= tbl_flag_q[rule_idx];
        end
    end
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = act_vld ? READ : IDLE;
            READ:    state_d = do_mod ? MOD : OUT;
            MOD:     state_d = WAIT;
            WAIT:    state_d = mod_done ? OUT : WAIT;
            OUT:     state_d = out_rdy ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        act_rdy    = state_q == IDLE;
        mod_enable = state_q == MOD;
        out_vld    = state_q == OUT;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            act_q        <= '0;
            hit_q        <= 1'b0;
            out_action_q <= '0;
            mod_action_q <= '0;
            mod_param_q  <= '0;
            mod_flag_q   <= '0;
            cnt_mod_q    <= '0;
            cnt_byp_q    <= '0;
        end else begin
            if (accept) begin
                act_q <= act_in;
                hit_q <= rule_hit;
            end
            if (state_q == READ && do_mod) begin
                mod_action_q <= act_q;
                mod_param_q  <= rd_param_q;
                mod_flag_q   <= rd_flag_q;
                cnt_mod_q    <= cnt_mod_q + 32'd1;
            end
            if (state_q == READ && !do_mod) begin
                out_action_q <= act_q;
                cnt_byp_q    <= cnt_byp_q + 32'd1;
            end
            if (state_q == WAIT && mod_done) out_action_q <= mod_result;
        end
    end
    assign mod_action   = mod_action_q;
    assign mod_param    = mod_param_q;
    assign mod_flag     = mod_flag_q;
    assign out_action   = out_action_q;
    assign cnt_modified = cnt_mod_q;
    assign cnt_bypass   = cnt_byp_q;
endmodule

// File: tb/tb_action_mod_sequencer.sv
// tb_action_mod_sequencer: vector table, directed corner cases and random traffic against a rule-level model
module tb_action_mod_sequencer;
    localparam int AW = 64;
    localparam int FW = 16;
    localparam int IW = 4;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          act_vld = 1'b0;
    logic [AW-1:0] act_in = '0;
    logic          rule_hit = 1'b0;
    logic [IW-1:0] rule_idx = '0;
    logic          act_rdy, mod_enable, mod_done, out_vld;
    logic [AW-1:0] mod_action, mod_param, out_action;
    logic [FW-1:0] mod_flag;
    logic          out_rdy = 1'b0;
    logic          tbl_wr_en = 1'b0;
    logic [IW-1:0] tbl_wr_addr = '0;
    logic [AW-1:0] tbl_wr_param = '0;
    logic [FW-1:0] tbl_wr_flag = '0;
    logic [31:0]   cnt_modified, cnt_bypass;
    logic          resp_done = 1'b0, man_done = 1'b0, pend = 1'b0, mod_auto = 1'b1;
    logic [AW-1:0] resp_res = '0;
    int            tests = 0, fails = 0;
    logic [AW-1:0] m_param [16];
    logic [FW-1:0] m_flag [16];
    logic [31:0]   mc_mod = 0, mc_byp = 0;

    action_mod_sequencer #(.ACTION_WIDTH(AW), .FLAG_WIDTH(FW), .RULE_IDX_WIDTH(IW)) dut (
        .clk(clk), .reset(reset), .act_vld(act_vld), .act_in(act_in), .rule_hit(rule_hit),
        .rule_idx(rule_idx), .act_rdy(act_rdy), .mod_enable(mod_enable), .mod_action(mod_action),
        .mod_param(mod_param), .mod_flag(mod_flag), .mod_result(resp_res), .mod_done(mod_done),
        .out_vld(out_vld), .out_action(out_action), .out_rdy(out_rdy), .tbl_wr_en(tbl_wr_en),
        .tbl_wr_addr(tbl_wr_addr), .tbl_wr_param(tbl_wr_param), .tbl_wr_flag(tbl_wr_flag),
        .cnt_modified(cnt_modified), .cnt_bypass(cnt_bypass)
    );

    always #5 clk = ~clk;

    // Modifier stand-in: flag bit 2 rewrites the 12-bit VLAN field, any other flag XORs in the param.
    function automatic logic [AW-1:0] mod_fn(input logic [AW-1:0] a, input logic [AW-1:0] p, input logic [FW-1:0] f);
        mod_fn = f[2] ? {a[AW-1:12], p[11:0]} : a ^ p;
    endfunction

    // Answers one cycle after the enable pulse, i.e. in the cycle the sequencer is waiting.
    always @(negedge clk) begin
        resp_done <= pend && mod_auto;
        resp_res  <= mod_fn(mod_action, mod_param, mod_flag);
        pend      <= mod_enable;
    end
    assign mod_done = resp_done || man_done;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic wr(input logic [IW-1:0] a, input logic [AW-1:0] p, input logic [FW-1:0] f);
        tbl_wr_en = 1'b1; tbl_wr_addr = a; tbl_wr_param = p; tbl_wr_flag = f;
        step();
        tbl_wr_en = 1'b0;
        m_param[a] = p; m_flag[a] = f;
    endtask

    // One full transaction; an optional table write to the same index rides in the accept cycle.
    task automatic txn(input string nm, input logic hit, input logic [IW-1:0] idx, input logic [AW-1:0] a,
                       input int bp, input logic we, input logic [AW-1:0] wp, input logic [FW-1:0] wf,
                       input logic [AW-1:0] exp_out, input int exp_lat);
        int t, lat, en_n, en_at;
        logic busy_bad, stall_bad;
        logic [AW-1:0] got;
        t = 0; busy_bad = 1'b0; stall_bad = 1'b0;
        while (!act_rdy && t < 20) begin step(); t++; end
        chk({nm, "_rdy"}, {63'd0, act_rdy}, 1);
        act_vld = 1'b1; act_in = a; rule_hit = hit; rule_idx = idx;
        tbl_wr_en = we; tbl_wr_addr = idx; tbl_wr_param = wp; tbl_wr_flag = wf;
        step();
        act_vld = 1'b0; tbl_wr_en = 1'b0;
        act_in = {$urandom, $urandom}; rule_hit = 1'($urandom); rule_idx = IW'($urandom);
        if (we) begin m_param[idx] = wp; m_flag[idx] = wf; end
        lat = 1; en_n = 0; en_at = -1;
        while (!out_vld && lat < 20) begin
            if (mod_enable) begin en_n++; if (en_at < 0) en_at = lat; end
            if (act_rdy) busy_bad = 1'b1;
            step(); lat++;
        end
        got = out_action;
        chk({nm, "_lat"}, AW'(lat), AW'(exp_lat));
        chk({nm, "_out"}, got, exp_out);
        chk({nm, "_en_pulses"}, AW'(en_n), AW'(exp_lat == 4 ? 1 : 0));
        chk({nm, "_en_cycle"}, AW'(en_at), AW'(exp_lat == 4 ? 2 : -1));
        chk({nm, "_busy_rdy"}, {63'd0, busy_bad}, 0);
        for (int i = 0; i < bp; i++) begin
            step();
            if (!out_vld || out_action !== got || act_rdy) stall_bad = 1'b1;
        end
        chk({nm, "_stall"}, {63'd0, stall_bad}, 0);
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        chk({nm, "_resume"}, {62'd0, act_rdy, out_vld}, 2);
        if (exp_lat == 4) mc_mod++; else mc_byp++;
        chk({nm, "_cnt_mod"}, AW'(cnt_modified), AW'(mc_mod));
        chk({nm, "_cnt_byp"}, AW'(cnt_bypass), AW'(mc_byp));
    endtask

    // Expected result from the rule model: modify only on a hit with a nonzero flag.
    task automatic rtxn(input string nm, input logic hit, input logic [IW-1:0] idx, input logic [AW-1:0] a,
                        input int bp, input logic we, input logic [AW-1:0] wp, input logic [FW-1:0] wf);
        logic m;
        m = hit && (m_flag[idx] != 0);
        txn(nm, hit, idx, a, bp, we, wp, wf, m ? mod_fn(a, m_param[idx], m_flag[idx]) : a, m ? 4 : 2);
    endtask

    typedef struct {
        logic          hit;
        logic [IW-1:0] idx;
        logic [AW-1:0] act;
        int            bp;
        logic [AW-1:0] exp_out;
        int            exp_lat;
    } vec_t;
    vec_t vecs [5];

    initial begin
        vecs[0] = '{1'b0, 4'd5, 64'hA5A5A5A5A5A5A5A5, 0, 64'hA5A5A5A5A5A5A5A5, 2};
        vecs[1] = '{1'b1, 4'd3, 64'h0123456789ABCDEF, 1, 64'h0123456789ABCDEF, 2};
        vecs[2] = '{1'b1, 4'd5, 64'hDEADBEEFCAFEF00D, 0, 64'hDEADBEEFCAFEF123, 4};
        vecs[3] = '{1'b1, 4'd7, 64'h0000000000001111, 2, 64'h000000000000EE11, 4};
        vecs[4] = '{1'b0, 4'd7, 64'h0000000000005555, 0, 64'h0000000000005555, 2};
        repeat (3) step();
        reset = 1'b0;
        chk("rst_rdy", {63'd0, act_rdy}, 1);
        chk("rst_vld_en", {62'd0, out_vld, mod_enable}, 0);
        chk("rst_out", out_action, 0);
        chk("rst_mod_act", mod_action, 0);
        chk("rst_mod_param", mod_param, 0);
        chk("rst_mod_flag", AW'(mod_flag), 0);
        chk("rst_cnts", {cnt_modified, cnt_bypass}, 0);
        for (int i = 0; i < 16; i++) wr(IW'(i), {$urandom, $urandom}, FW'($urandom));
        wr(4'd3, 64'h0000_0000_0000_0FFF, 16'h0000);
        wr(4'd5, 64'h0000_0000_0000_0123, 16'h0004);
        wr(4'd7, 64'h0000_0000_0000_FF00, 16'h0001);
        wr(4'd2, 64'h0000_0000_0000_0AAA, 16'h0004);
        for (int i = 0; i < 5; i++)
            txn($sformatf("vec%0d", i), vecs[i].hit, vecs[i].idx, vecs[i].act, vecs[i].bp, 1'b0, '0, '0,
                vecs[i].exp_out, vecs[i].exp_lat);
        txn("bp10", 1'b1, 4'd5, 64'h0F0F0F0F0F0F0F0F, 10, 1'b0, '0, '0, 64'h0F0F0F0F0F0F0123, 4);
        txn("wr_same_old", 1'b1, 4'd2, 64'h1234567812345678, 0, 1'b1, 64'h0BBB, 16'h0004,
            64'h1234567812345AAA, 4);
        txn("wr_same_new", 1'b1, 4'd2, 64'h1234567812345678, 0, 1'b0, '0, '0, 64'h1234567812345BBB, 4);
        mod_auto = 1'b0;
        act_vld = 1'b1; act_in = 64'h7777; rule_hit = 1'b1; rule_idx = 4'd5;
        step();
        act_vld = 1'b0;
        step(); step();
        chk("wait_state", {61'd0, act_rdy, out_vld, mod_enable}, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        mc_mod = 0; mc_byp = 0;
        chk("wait_rst_rdy", {62'd0, act_rdy, out_vld}, 2);
        chk("wait_rst_cnts", {cnt_modified, cnt_bypass}, 0);
        chk("wait_rst_out", out_action, 0);
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        step();
        chk("late_done", {62'd0, act_rdy, out_vld}, 2);
        chk("late_done_cnts", {cnt_modified, cnt_bypass}, 0);
        mod_auto = 1'b1;
        txn("post_rst_mod", 1'b1, 4'd5, 64'hFFFF_0000_FFFF_0000, 0, 1'b0, '0, '0, 64'hFFFF_0000_FFFF_0123, 4);
        force dut.cnt_byp_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_byp_q;
        mc_byp = 32'hFFFF_FFFF;
        txn("wrap", 1'b0, 4'd0, 64'h42, 0, 1'b0, '0, '0, 64'h42, 2);
        chk("wrap_zero", AW'(cnt_bypass), 0);
        for (int n = 0; n < 60; n++) begin
            logic [IW-1:0] ri;
            ri = IW'($urandom);
            if ($urandom_range(0, 2) == 0)
                wr(IW'($urandom), {$urandom, $urandom}, ($urandom_range(0, 2) == 0) ? 16'h0 : FW'($urandom));
            rtxn($sformatf("rnd%0d", n), 1'($urandom), ri, {$urandom, $urandom}, $urandom_range(0, 3),
                 $urandom_range(0, 5) == 0, {$urandom, $urandom}, FW'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
